// File: rtl/mem_access_unit.sv
// Load/store unit between the core controller and a simple req/ack memory bus.
// Handles word and byte accesses, alignment faults and ack timeouts.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_load;
  logic             byte_q;
  logic [1:0]       lane;
  logic             mem_req;
  logic             aligned;
  logic [7:0]       lane_byte;

  assign mem_req   = mem_read | mem_write;
  assign aligned   = byte_en | (addr[1:0] == 2'b00);
  assign lane_byte = 8'(bus_rdata >> {lane, 3'b000});

  // Core is held while a request waits in IDLE and for the whole bus access.
  assign stall = reset & (((state == IDLE) & mem_req) | (state == ACCESS));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_load   <= 1'b0;
      byte_q    <= 1'b0;
      lane      <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      read_data <= '0;
      fault     <= 1'b0;
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            is_load <= ~mem_write;
            byte_q  <= byte_en;
            lane    <= addr[1:0];
            if (aligned) begin
              state     <= ACCESS;
              cnt       <= '0;
              bus_req   <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= byte_en ? (4'b0001 << addr[1:0]) : 4'b1111;
              bus_wdata <= byte_en ? {4{write_data[7:0]}} : write_data;
            end else begin
              // Misaligned word: fault without touching the bus.
              state <= DONE;
              fault <= 1'b1;
              if (!mem_write) read_data <= '0;
            end
          end
        end
        ACCESS: begin
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            if (is_load) read_data <= byte_q ? {24'd0, lane_byte} : bus_rdata;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= DONE;
            bus_req <= 1'b0;
            fault   <= 1'b1;
            if (is_load) read_data <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_mem_access_unit;

  localparam int unsigned TO = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, byte_en;
  logic [31:0] addr, write_data, read_data;
  logic        stall, fault;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_rd = '0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .byte_en(byte_en), .addr(addr), .write_data(write_data),
    .read_data(read_data), .stall(stall), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete instruction; delay = ACCESS cycles before ack, <0 = never.
  task automatic run_txn(input string tag, input logic rd, input logic wr,
                         input logic bsel, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         input int delay);
    bit          aligned, tout, done, exp_fault;
    int          acc_len, stalls, reqs, bad_bus, early_fault;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;

    aligned   = bsel || (a[1:0] == 2'b00);
    tout      = aligned && (delay < 0 || delay >= int'(TO));
    acc_len   = !aligned ? 0 : (tout ? int'(TO) : delay + 1);
    exp_fault = !aligned || tout;
    exp_be    = bsel ? 4'(1 << a[1:0]) : 4'hF;
    exp_wd    = bsel ? {4{wd[7:0]}} : wd;
    if (!wr) begin
      if (exp_fault)  model_rd = '0;
      else if (bsel)  model_rd = (rdat >> (8 * a[1:0])) & 32'hFF;
      else            model_rd = rdat;
    end

    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; byte_en = bsel; addr = a; write_data = wd;
    stalls = 0; reqs = 0; bad_bus = 0; early_fault = 0; done = 0;
    for (int cyc = 0; cyc < int'(TO) + 20 && !done; cyc++) begin
      @(negedge clk);
      if (stall) begin
        stalls++;
        if (fault) early_fault++;
      end else begin
        done = 1;
      end
      if (bus_req) begin
        reqs++;
        if (bus_addr !== {a[31:2], 2'b00} || bus_be !== exp_be || bus_we !== wr ||
            (wr && bus_wdata !== exp_wd)) bad_bus++;
        if (reqs - 1 == delay) begin bus_ack = 1'b1; bus_rdata = rdat; end
        else begin bus_ack = 1'b0; bus_rdata = $urandom; end
      end else begin
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(acc_len + 1));
    chk({tag, "_req_cycles"}, 32'(reqs), 32'(acc_len));
    chk({tag, "_bus_fields"}, 32'(bad_bus), 32'd0);
    chk({tag, "_early_fault"}, 32'(early_fault), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'(exp_fault));
    chk({tag, "_read_data"}, read_data, model_rd);

    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; addr = $urandom;
    @(negedge clk);
    chk({tag, "_after_stall"}, 32'(stall), 32'd0);
    chk({tag, "_after_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_after_fault"}, 32'(fault), 32'd0);
    chk({tag, "_after_rd"}, read_data, model_rd);
  endtask

  initial begin
    int seen;
    logic rd, wr, bs;
    logic [31:0] a;

    // Reset with a request pending: outputs cleared and no stall.
    reset = 1'b0; mem_read = 1'b1; mem_write = 1'b0; byte_en = 1'b0;
    addr = 32'h100; write_data = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    mem_read = 1'b0; reset = 1'b1;

    // Non-memory instructions with stray acks: nothing happens.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_ack = 1'b1; bus_rdata = $urandom; addr = $urandom;
      @(negedge clk);
      chk("nomem_stall", 32'(stall), 32'd0);
      chk("nomem_req", 32'(bus_req), 32'd0);
      chk("nomem_rd", read_data, 32'd0);
    end
    bus_ack = 1'b0;

    run_txn("word_load_0wait", 1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    run_txn("byte_store_203", 0, 1, 1, 32'h203, 32'h123456AB, 32'h0, 2);
    run_txn("byte_load_102", 1, 0, 1, 32'h102, 32'h0, 32'h11223344, 5);
    run_txn("misalign_load", 1, 0, 0, 32'h101, 32'h0, 32'hCAFEF00D, 0);
    run_txn("word_store", 0, 1, 0, 32'h400, 32'hA5A5_1234, 32'h0, 1);
    run_txn("byte_load_0wait", 1, 0, 1, 32'h7, 32'h0, 32'h8899AABB, 0);
    run_txn("misalign_store", 0, 1, 0, 32'h402, 32'h55, 32'h0, 0);
    run_txn("both_req_store", 1, 1, 0, 32'h40, 32'h0BAD_CAFE, 32'hFFFF_FFFF, 0);
    run_txn("timeout_load", 1, 0, 0, 32'h800, 32'h0, 32'h1234_5678, -1);
    run_txn("ack_last_cycle", 1, 0, 0, 32'h804, 32'h0, 32'h7777_0001, int'(TO) - 1);

    // Reset in the third ACCESS cycle, ack arriving afterwards.
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; byte_en = 1'b0; addr = 32'h300; bus_ack = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 10 && seen < 3; cyc++) begin
      @(negedge clk);
      if (bus_req) seen++;
    end
    chk("rst_access_reached", 32'(seen), 32'd3);
    reset = 1'b0;
    #1;
    chk("rst_access_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFEED_FACE;
    model_rd = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_access_req", 32'(bus_req), 32'd0);
      chk("rst_access_stall2", 32'(stall), 32'd0);
      chk("rst_access_fault", 32'(fault), 32'd0);
      chk("rst_access_rd", read_data, model_rd);
    end
    bus_ack = 1'b0;

    // Random traffic.
    for (int i = 0; i < 24; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      bs = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && !bs) a[1:0] = 2'b00;
      run_txn("rand", rd, wr, bs, a, $urandom, $urandom, int'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning the maximum ACCESS cycles waited for bus_ack before a fault.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-004 SHALL have port mem_read  input  1  load request from core controller.
REQ-005 SHALL have port mem_write  input  1  store request from core controller.
REQ-006 SHALL have port byte_en  input  1  1 = byte access (LDRB/STRB), 0 = word access.
REQ-007 SHALL have port addr  input  32  byte address from datapath ALU result.
REQ-008 SHALL have port write_data  input  32  store data from register file.
REQ-009 SHALL have port read_data  output  32  load result to datapath result mux.
REQ-010 SHALL have port stall  output  1  1 = core holds PC and register writes this cycle.
REQ-011 SHALL have port fault  output  1  one-cycle pulse on misalignment or timeout.
REQ-012 SHALL have bus ports bus_req out 1, bus_we out 1, bus_addr out 32, bus_wdata out 32, bus_be out 4, bus_ack in 1, bus_rdata in 32.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, DONE; one-hot or binary encoding is free.
REQ-014 IDLE with mem_write=1 or mem_read=1 SHALL latch request; mem_write SHALL win when both are 1 (store).
REQ-015 IDLE, aligned request (byte_en=1, or addr[1:0]=00) SHALL go to ACCESS with bus_req=1 from the next cycle.
REQ-016 IDLE, misaligned word request SHALL go to DONE without a bus transaction; fault=1 in that DONE cycle; read_data unchanged for stores, 0 for loads.
REQ-017 bus_addr SHALL be {addr[31:2],2'b00}; bus_we SHALL be 1 for stores.
REQ-018 bus_be SHALL be 4'b1111 for word, 4'b0001<<addr[1:0] for byte (little-endian).
REQ-019 bus_wdata SHALL be write_data for word stores, {4{write_data[7:0]}} for byte stores.
REQ-020 bus_req, bus_we, bus_addr, bus_wdata, bus_be SHALL be registered and stable throughout ACCESS.
REQ-021 ACCESS SHALL exit to DONE on the first cycle bus_ack=1 is sampled, deasserting bus_req from the next cycle.
REQ-022 On ack for a load, read_data SHALL be bus_rdata (word) or zero-extended bus_rdata byte lane addr[1:0] (byte), registered into DONE.
REQ-023 A cycle counter SHALL count ACCESS cycles; on reaching TIMEOUT without ack, go to DONE, drop bus_req, fault=1, read_data=0 for loads.
REQ-024 DONE SHALL last exactly one cycle and return to IDLE unconditionally; requests still asserted in DONE SHALL NOT retrigger.
REQ-025 stall SHALL be combinational: 1 in IDLE with a request present, 1 throughout ACCESS, 0 in DONE and idle IDLE.
REQ-026 Zero-wait ack (ack in first ACCESS cycle) SHALL yield a 3-cycle instruction: stall high 2 cycles, DONE third.
REQ-027 bus_ack or bus_rdata outside ACCESS SHALL be ignored.
REQ-028 read_data SHALL hold its value until the next load completes or faults.
REQ-029 Non-memory instructions (both requests 0) SHALL pass with stall=0 and no bus activity.

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE, counter=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, read_data=0, fault=0.
REQ-031 reset during ACCESS SHALL deassert bus_req at that edge; a later bus_ack SHALL be ignored and no fault raised.
REQ-032 stall SHALL be 0 while reset=0 regardless of requests.

Verification
REQ-033 Word load addr=0x100, ack in first ACCESS cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x100, be=1111, stall 2 cycles, read_data=0xDEADBEEF in DONE.
REQ-034 Byte store addr=0x203, write_data=0x123456AB -> be=1000, bus_wdata=0xABABABAB, bus_we=1, fault=0.
REQ-035 Byte load addr=0x102, bus_rdata=0x11223344, ack after 5 cycles -> read_data=0x00000022, stall 7 cycles total.
REQ-036 Word load addr=0x101 -> no bus_req, fault=1 one cycle, read_data=0, stall 1 cycle.
REQ-037 Load, bus_ack never asserted, TIMEOUT=256 -> bus_req for 256 cycles, then fault=1, read_data=0, FSM back in IDLE.
REQ-038 reset=0 in third ACCESS cycle, ack asserted next cycle -> bus_req=0, IDLE, read_data=0, fault=0, no DONE.
